// File: rtl/ball_outcome_scorer.sv
// Cricket delivery scorer: turns an LFSR sample on each bowl press into an outcome
// and keeps the innings tally (runs, wickets, balls, overs) until the innings ends.
module ball_outcome_scorer #(
    parameter int MAX_OVERS   = 2,
    parameter int MAX_WICKETS = 10,
    parameter int TARGET      = 0
) (
    input  logic       clk_fpga,
    input  logic       reset,
    input  logic       bowl_btn,
    input  logic [3:0] rand_in,
    output logic [7:0] runs,
    output logic [3:0] wickets,
    output logic [2:0] balls,
    output logic [3:0] overs,
    output logic [3:0] last_outcome,
    output logic       outcome_valid,
    output logic       game_over
);

    typedef enum logic [1:0] {IDLE, EVAL, OVER} state_t;

    localparam logic [3:0] MAX_OVERS_L   = 4'(MAX_OVERS);
    localparam logic [3:0] MAX_WICKETS_L = 4'(MAX_WICKETS);
    localparam logic [7:0] TARGET_L      = 8'(TARGET);
    localparam logic [3:0] WICKET_CODE   = 4'hF;

    state_t     state_reg, state_next;
    logic       bowl_d_reg;
    logic [3:0] sample_reg, sample_next;
    logic [7:0] runs_reg, runs_next;
    logic [3:0] wickets_reg, wickets_next;
    logic [2:0] balls_reg, balls_next;
    logic [3:0] overs_reg, overs_next;
    logic [3:0] last_reg, last_next;
    logic       valid_reg, valid_next;

    logic       bowl_evt;
    logic [3:0] delta;
    logic       is_wicket;
    logic [8:0] run_sum;
    logic       end_hit;

    assign bowl_evt = bowl_btn & ~bowl_d_reg;

    // LFSR sample to delivery outcome; wickets carry no runs.
    always_comb begin
        delta     = 4'd0;
        is_wicket = 1'b0;
        case (sample_reg)
            4'd0, 4'd1:          delta = 4'd0;
            4'd2, 4'd3, 4'd4:    delta = 4'd1;
            4'd5, 4'd6:          delta = 4'd2;
            4'd7:                delta = 4'd3;
            4'd8, 4'd9, 4'd10:   delta = 4'd4;
            4'd11, 4'd12:        delta = 4'd6;
            default:             is_wicket = 1'b1;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        sample_next  = sample_reg;
        runs_next    = runs_reg;
        wickets_next = wickets_reg;
        balls_next   = balls_reg;
        overs_next   = overs_reg;
        last_next    = last_reg;
        valid_next   = 1'b0;
        run_sum      = {1'b0, runs_reg} + {5'd0, delta};
        end_hit      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (bowl_evt) begin
                    sample_next = rand_in;
                    state_next  = EVAL;
                end
            end
            EVAL: begin
                runs_next = run_sum[8] ? 8'hFF : run_sum[7:0];
                if (is_wicket) begin
                    wickets_next = wickets_reg + 4'd1;
                end
                if (balls_reg == 3'd5) begin
                    balls_next = 3'd0;
                    overs_next = overs_reg + 4'd1;
                end else begin
                    balls_next = balls_reg + 3'd1;
                end
                last_next  = is_wicket ? WICKET_CODE : delta;
                valid_next = 1'b1;
                // End checks look at the post-update tallies.
                end_hit = (wickets_next == MAX_WICKETS_L) ||
                          (overs_next == MAX_OVERS_L) ||
                          ((TARGET_L != 8'd0) && (runs_next >= TARGET_L));
                state_next = end_hit ? OVER : IDLE;
            end
            OVER: begin
                state_next = OVER;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            state_reg   <= IDLE;
            bowl_d_reg  <= 1'b1;
            sample_reg  <= 4'd0;
            runs_reg    <= 8'd0;
            wickets_reg <= 4'd0;
            balls_reg   <= 3'd0;
            overs_reg   <= 4'd0;
            last_reg    <= 4'd0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bowl_d_reg  <= bowl_btn;
            sample_reg  <= sample_next;
            runs_reg    <= runs_next;
            wickets_reg <= wickets_next;
            balls_reg   <= balls_next;
            overs_reg   <= overs_next;
            last_reg    <= last_next;
            valid_reg   <= valid_next;
        end
    end

    assign runs          = runs_reg;
    assign wickets       = wickets_reg;
    assign balls         = balls_reg;
    assign overs         = overs_reg;
    assign last_outcome  = last_reg;
    assign outcome_valid = valid_reg;
    assign game_over     = (state_reg == OVER);

endmodule

// File: tb/tb_ball_outcome_scorer.sv
// Directed bench for ball_outcome_scorer: four instances with different limits share
// one stimulus stream; each test checks the instance whose limits it exercises.
module tb_ball_outcome_scorer;

    logic       clk_fpga = 1'b0;
    logic       reset    = 1'b1;
    logic       bowl_btn = 1'b0;
    logic [3:0] rand_in  = 4'd0;

    logic [7:0] runs_o    [4];
    logic [3:0] wickets_o [4];
    logic [2:0] balls_o   [4];
    logic [3:0] overs_o   [4];
    logic [3:0] last_o    [4];
    logic       valid_o   [4];
    logic       over_o    [4];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_fpga = ~clk_fpga;

    // 0: defaults, 1: wicket limit 3, 2: target 10, 3: fifteen overs
    ball_outcome_scorer #(.MAX_OVERS(2), .MAX_WICKETS(10), .TARGET(0)) u_def (
        .clk_fpga(clk_fpga), .reset(reset), .bowl_btn(bowl_btn), .rand_in(rand_in),
        .runs(runs_o[0]), .wickets(wickets_o[0]), .balls(balls_o[0]), .overs(overs_o[0]),
        .last_outcome(last_o[0]), .outcome_valid(valid_o[0]), .game_over(over_o[0]));
    ball_outcome_scorer #(.MAX_OVERS(2), .MAX_WICKETS(3), .TARGET(0)) u_wk (
        .clk_fpga(clk_fpga), .reset(reset), .bowl_btn(bowl_btn), .rand_in(rand_in),
        .runs(runs_o[1]), .wickets(wickets_o[1]), .balls(balls_o[1]), .overs(overs_o[1]),
        .last_outcome(last_o[1]), .outcome_valid(valid_o[1]), .game_over(over_o[1]));
    ball_outcome_scorer #(.MAX_OVERS(2), .MAX_WICKETS(10), .TARGET(10)) u_tg (
        .clk_fpga(clk_fpga), .reset(reset), .bowl_btn(bowl_btn), .rand_in(rand_in),
        .runs(runs_o[2]), .wickets(wickets_o[2]), .balls(balls_o[2]), .overs(overs_o[2]),
        .last_outcome(last_o[2]), .outcome_valid(valid_o[2]), .game_over(over_o[2]));
    ball_outcome_scorer #(.MAX_OVERS(15), .MAX_WICKETS(10), .TARGET(0)) u_sat (
        .clk_fpga(clk_fpga), .reset(reset), .bowl_btn(bowl_btn), .rand_in(rand_in),
        .runs(runs_o[3]), .wickets(wickets_o[3]), .balls(balls_o[3]), .overs(overs_o[3]),
        .last_outcome(last_o[3]), .outcome_valid(valid_o[3]), .game_over(over_o[3]));

    typedef struct {
        logic [3:0] rnd;
        logic [3:0] exp_last;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
            $display("ok   %s: got %0d", name, act);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk_fpga);
        reset = 1'b1; bowl_btn = 1'b0; rand_in = 4'd0;
        repeat (2) @(negedge clk_fpga);
        reset = 1'b0;
    endtask

    // One-cycle press; the pulse must land exactly two edges after the press cycle.
    task automatic bowl(input int d, input logic [3:0] r, input bit exp_pulse, output bit go_at_pulse);
        @(negedge clk_fpga);
        bowl_btn = 1'b1; rand_in = r;
        @(negedge clk_fpga);
        bowl_btn = 1'b0; rand_in = ~r;
        chk("no_early_pulse", int'(valid_o[d]), 0);
        @(negedge clk_fpga);
        chk("pulse", int'(valid_o[d]), int'(exp_pulse));
        go_at_pulse = over_o[d];
        @(negedge clk_fpga);
        chk("pulse_one_cycle", int'(valid_o[d]), 0);
    endtask

    initial begin
        bit go;
        int pulses;
        int m_runs, m_wk, m_balls, m_overs;
        logic [3:0] sweep_r [6];
        logic [3:0] sweep_e [6];

        vecs = '{'{4'd0, 4'd0}, '{4'd1, 4'd0}, '{4'd2, 4'd1}, '{4'd3, 4'd1},
                 '{4'd4, 4'd1}, '{4'd5, 4'd2}, '{4'd6, 4'd2}, '{4'd7, 4'd3},
                 '{4'd8, 4'd4}, '{4'd9, 4'd4}, '{4'd10, 4'd4}, '{4'd11, 4'd6},
                 '{4'd12, 4'd6}, '{4'd13, 4'hF}, '{4'd14, 4'hF}, '{4'd15, 4'hF}};
        sweep_r = '{4'd0, 4'd3, 4'd6, 4'd7, 4'd11, 4'd14};
        sweep_e = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'hF};

        // Reset state
        apply_reset();
        @(negedge clk_fpga);
        for (int d = 0; d < 4; d++) begin
            chk("rst_runs", int'(runs_o[d]), 0);
            chk("rst_wickets", int'(wickets_o[d]), 0);
            chk("rst_balls", int'(balls_o[d]), 0);
            chk("rst_overs", int'(overs_o[d]), 0);
            chk("rst_last", int'(last_o[d]), 0);
            chk("rst_valid", int'(valid_o[d]), 0);
            chk("rst_game_over", int'(over_o[d]), 0);
        end

        // Latency with a held button: exactly one pulse two edges after the press
        rand_in = 4'd8;
        repeat (10) @(negedge clk_fpga);
        bowl_btn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_fpga);
            chk($sformatf("held_valid_c%0d", k), int'(valid_o[0]), (k == 2) ? 1 : 0);
        end
        chk("lat_last", int'(last_o[0]), 4);
        chk("lat_runs", int'(runs_o[0]), 4);
        chk("lat_balls", int'(balls_o[0]), 1);
        bowl_btn = 1'b0;

        // Full decode table on the fifteen-over instance, tallies tracked by a model
        apply_reset();
        m_runs = 0; m_wk = 0; m_balls = 0; m_overs = 0;
        for (int i = 0; i < 16; i++) begin
            bowl(3, vecs[i].rnd, 1'b1, go);
            if (vecs[i].exp_last == 4'hF) m_wk++;
            else m_runs += int'(vecs[i].exp_last);
            if (m_balls == 5) begin m_balls = 0; m_overs++; end
            else m_balls++;
            chk($sformatf("dec_last_r%0d", vecs[i].rnd), int'(last_o[3]), int'(vecs[i].exp_last));
            chk("dec_runs", int'(runs_o[3]), m_runs);
            chk("dec_wickets", int'(wickets_o[3]), m_wk);
            chk("dec_balls", int'(balls_o[3]), m_balls);
            chk("dec_overs", int'(overs_o[3]), m_overs);
        end

        // Six-ball sweep on the default instance
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            bowl(0, sweep_r[i], 1'b1, go);
            chk($sformatf("sweep_last_%0d", i), int'(last_o[0]), int'(sweep_e[i]));
        end
        chk("sweep_runs", int'(runs_o[0]), 12);
        chk("sweep_wickets", int'(wickets_o[0]), 1);
        chk("sweep_balls", int'(balls_o[0]), 0);
        chk("sweep_overs", int'(overs_o[0]), 1);
        chk("sweep_not_over", int'(over_o[0]), 0);

        // Overs limit: twelve singles end the innings on the 12th pulse
        apply_reset();
        for (int i = 1; i <= 12; i++) begin
            bowl(0, 4'd2, 1'b1, go);
            chk($sformatf("ovl_go_at_pulse_%0d", i), int'(go), (i == 12) ? 1 : 0);
        end
        chk("ovl_runs", int'(runs_o[0]), 12);
        chk("ovl_overs", int'(overs_o[0]), 2);
        chk("ovl_balls", int'(balls_o[0]), 0);
        bowl(0, 4'd11, 1'b0, go);
        chk("ovl_13_runs_hold", int'(runs_o[0]), 12);
        chk("ovl_13_last_hold", int'(last_o[0]), 1);
        chk("ovl_13_game_over", int'(over_o[0]), 1);

        // Wicket limit of three
        apply_reset();
        for (int i = 1; i <= 3; i++) begin
            bowl(1, 4'd15, 1'b1, go);
            chk($sformatf("wkl_go_at_pulse_%0d", i), int'(go), (i == 3) ? 1 : 0);
        end
        chk("wkl_wickets", int'(wickets_o[1]), 3);
        chk("wkl_runs", int'(runs_o[1]), 0);
        chk("wkl_last", int'(last_o[1]), 15);

        // Target of ten: two sixes reach it
        apply_reset();
        bowl(2, 4'd11, 1'b1, go);
        chk("tgt_go_first", int'(go), 0);
        bowl(2, 4'd11, 1'b1, go);
        chk("tgt_go_second", int'(go), 1);
        chk("tgt_runs", int'(runs_o[2]), 12);

        // Saturation: 43 sixes would make 258
        apply_reset();
        for (int i = 1; i <= 43; i++) begin
            bowl(3, 4'd12, 1'b1, go);
            if (i == 42) chk("sat_runs_42", int'(runs_o[3]), 252);
        end
        chk("sat_runs_43", int'(runs_o[3]), 255);
        chk("sat_overs", int'(overs_o[3]), 7);
        chk("sat_balls", int'(balls_o[3]), 1);
        chk("sat_not_over", int'(over_o[3]), 0);

        // Reset landing on the EVAL cycle suppresses the pulse
        apply_reset();
        bowl(0, 4'd8, 1'b1, go);
        @(negedge clk_fpga);
        bowl_btn = 1'b1; rand_in = 4'd11;
        @(negedge clk_fpga);
        bowl_btn = 1'b0; reset = 1'b1;
        @(negedge clk_fpga);
        chk("evrst_valid", int'(valid_o[0]), 0);
        chk("evrst_runs", int'(runs_o[0]), 0);
        chk("evrst_balls", int'(balls_o[0]), 0);
        chk("evrst_last", int'(last_o[0]), 0);
        reset = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk_fpga);
            if (valid_o[0]) pulses++;
        end
        chk("evrst_no_late_pulse", pulses, 0);

        // Button held through reset release must not bowl
        @(negedge clk_fpga);
        reset = 1'b1; bowl_btn = 1'b1; rand_in = 4'd8;
        repeat (2) @(negedge clk_fpga);
        reset = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk_fpga);
            if (valid_o[0]) pulses++;
        end
        chk("held_rst_pulses", pulses, 0);
        chk("held_rst_balls", int'(balls_o[0]), 0);
        bowl_btn = 1'b0;
        bowl(0, 4'd7, 1'b1, go);
        chk("held_rst_repress_last", int'(last_o[0]), 3);
        chk("held_rst_repress_runs", int'(runs_o[0]), 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
